// File: rtl/serial_add2_ctrl_if.sv
// Operand/result handshake bundle for the digit-serial add/subtract sequencer.
// The operand source and result sink use the master view; the sequencer uses
// the slave view.
interface serial_add2_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Status
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_add2_ctrl.sv
// Digit-serial add/subtract sequencer around a single 2-bit full-adder slice.
// Operands are captured on an in_valid/in_ready handshake, processed two bits
// per clock LSB digit first with a registered carry, and the WIDTH-bit result
// plus carry-out is offered on an out_valid/out_ready handshake.
// Subtraction is a + ~b + 1; cout=1 then means no borrow (a >= b unsigned).
module serial_add2_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_n,
  serial_add2_ctrl_if.slave  bus
);

  localparam int unsigned D  = WIDTH / 2;
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_add2_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             carry_q,     carry_d;
  logic             cout_q,      cout_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    cnt_q,       cnt_d;

  logic [2:0]       digit;       // {carry, s[1:0]} from the 2-bit slice
  logic             in_ready;
  logic             accept;
  logic             last_digit;

  // The shared 2-bit adder slice: low digits of the shift registers plus carry.
  assign digit      = {1'b0, a_q[1:0]} + {1'b0, b_q[1:0]} + {2'b00, carry_q};

  // Operands are never taken while reset is held, even if state reads IDLE.
  assign in_ready   = rst_n && (state_q == IDLE);
  assign accept     = bus.in_valid && in_ready;
  assign last_digit = (cnt_q == CW'(D - 1));

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = (state_q != IDLE);

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        carry_d = digit[2];
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        // New digit enters at the MSB end; after D digits the result is LSB-aligned.
        sum_d   = (sum_q >> 2) | (WIDTH'(digit[1:0]) << (WIDTH - 2));
        if (last_digit) begin
          cout_d      = digit[2];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        // sum/cout hold here and through the following IDLE until next accept.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any operation.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: these are plain flops, not a memory array, so clearing all of
      // them on reset is cheap and makes post-reset outputs deterministic.
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_add2_ctrl.sv
// Self-checking bench for serial_add2_ctrl (WIDTH=8, four digits).
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_add2_ctrl;

  localparam int unsigned W   = 8;
  localparam int unsigned D   = W / 2;
  localparam int          NRND = 1000;

  logic clk_in;
  logic rst_n;

  int vectors;
  int miscompares;

  serial_add2_ctrl_if #(.WIDTH(W)) bus ();

  serial_add2_ctrl #(.WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: {cout, sum} from unsigned integer arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mcin, input logic msub);
    int unsigned ia, ib, r;
    ia = ma;
    ib = mb;
    if (msub) begin
      r = (ia - ib) & ((1 << W) - 1);
      return {(ia >= ib), r[W-1:0]};
    end
    r = ia + ib + (mcin ? 1 : 0);
    return r[W:0];
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Presents one operand pair, waits for acceptance, then scrambles the operand
  // inputs and counts edges until out_valid. Leaves the result pending in DONE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tcin, input logic tsub,
                        output int lat, output logic [W-1:0] rsum,
                        output logic rcout, output bit timeout);
    int g;
    timeout = 0;
    lat = 0;
    rsum = '0;
    rcout = 1'b0;
    bus.a = ta;
    bus.b = tbv;
    bus.cin = tcin;
    bus.sub = tsub;
    bus.in_valid = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      tick();
      g++;
    end
    if (!bus.in_ready) begin
      timeout = 1;
      bus.in_valid = 1'b0;
      return;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.cin = 1'($urandom);
    bus.sub = 1'($urandom);
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) timeout = 1;
    rsum  = bus.sum;
    rcout = bus.cout;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    tick();
    vectors++;
    if ({bus.out_valid, bus.busy, bus.cout, bus.sum, bus.in_ready} !== {3'b000, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got ov=%b busy=%b cout=%b sum=%h rdy=%b expected 0,0,0,00,0",
               bus.out_valid, bus.busy, bus.cout, bus.sum, bus.in_ready);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got rdy=%b busy=%b expected 1,0", bus.in_ready, bus.busy);
    end
  endtask

  // Runs one directed operation and checks latency, sum, cout and return to IDLE.
  task automatic directed(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tcin, input logic tsub, input logic [W:0] spec_exp);
    int lat;
    logic [W-1:0] rs;
    logic rc;
    bit to;
    logic [W:0] e;
    e = model(ta, tbv, tcin, tsub);
    run_op(ta, tbv, tcin, tsub, lat, rs, rc, to);
    vectors++;
    if (to || lat != D) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d (timeout=%0d) expected %0d", nm, lat, to, D);
    end
    vectors++;
    if ({rc, rs} !== e || e !== spec_exp) begin
      miscompares++;
      $display("FAIL %s_result: got cout=%b sum=%h expected cout=%b sum=%h", nm, rc, rs, spec_exp[W], spec_exp[W-1:0]);
    end
    vectors++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_flags: got busy=%b rdy=%b expected 1,0", nm, bus.busy, bus.in_ready);
    end
    take_result();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || {bus.cout, bus.sum} !== spec_exp) begin
      miscompares++;
      $display("FAIL %s_idle: got ov=%b busy=%b rdy=%b cout=%b sum=%h expected 0,0,1,%b,%h",
               nm, bus.out_valid, bus.busy, bus.in_ready, bus.cout, bus.sum, spec_exp[W], spec_exp[W-1:0]);
    end
  endtask

  task automatic test_add();
    directed("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096);
  endtask

  task automatic test_carry();
    directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
    directed("add_ff_00_cin", 8'hFF, 8'h00, 1'b1, 1'b0, 9'h100);
  endtask

  task automatic test_sub();
    directed("sub_10_01", 8'h10, 8'h01, 1'b1, 1'b1, 9'h10F);
    directed("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 9'h0FF);
  endtask

  task automatic test_done_hold();
    int lat;
    logic [W-1:0] rs;
    logic rc;
    bit to;
    logic [W:0] e;
    e = model(8'hC3, 8'h5E, 1'b1, 1'b0);
    run_op(8'hC3, 8'h5E, 1'b1, 1'b0, lat, rs, rc, to);
    vectors++;
    if (to || {rc, rs} !== e) begin
      miscompares++;
      $display("FAIL hold_initial: got cout=%b sum=%h expected cout=%b sum=%h", rc, rs, e[W], e[W-1:0]);
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.cout, bus.sum} !== e) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: got ov=%b rdy=%b cout=%b sum=%h expected 1,0,%b,%h",
                 i, bus.out_valid, bus.in_ready, bus.cout, bus.sum, e[W], e[W-1:0]);
      end
    end
    bus.in_valid = 1'b0;
    take_result();
    // out_ready while nothing is pending must not start or change anything.
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || {bus.cout, bus.sum} !== e) begin
      miscompares++;
      $display("FAIL hold_no_capture: got busy=%b ov=%b cout=%b sum=%h expected 0,0,%b,%h",
               bus.busy, bus.out_valid, bus.cout, bus.sum, e[W], e[W-1:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [W-1:0] rs;
    logic rc;
    bit to;
    bit seen;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.cin = 1'b1;
    bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    tick();              // accept edge
    bus.in_valid = 1'b0;
    tick();              // RUN edge 1
    tick();              // RUN edge 2
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 8'h00 || bus.busy !== 1'b0 || bus.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: got ov=%b sum=%h busy=%b cout=%b expected 0,00,0,0",
               bus.out_valid, bus.sum, bus.busy, bus.cout);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) seen = 1;
      tick();
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL midrun_no_result: got out_valid=1 after abort expected 0");
    end
    run_op(8'h01, 8'h01, 1'b0, 1'b0, lat, rs, rc, to);
    vectors++;
    if (to || rs !== 8'h02 || rc !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_recover: got cout=%b sum=%h expected 0,02", rc, rs);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [W:0] expq[$];
    logic [W:0] e;
    int sent, got, cyc, last_out;
    bit acc, rel;
    sent = 0;
    got = 0;
    cyc = 0;
    last_out = -1;
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.cin = 1'($urandom);
    bus.sub = 1'($urandom);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (got < NRND && cyc < NRND * 6 + 50) begin
      acc = bus.in_valid && bus.in_ready;
      rel = bus.out_valid && bus.out_ready;
      if (rel) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_spurious: got out_valid with no pending operation at cycle %0d", cyc);
        end else begin
          e = expq.pop_front();
          if ({bus.cout, bus.sum} !== e) begin
            miscompares++;
            $display("FAIL b2b_result%0d: got cout=%b sum=%h expected cout=%b sum=%h",
                     got, bus.cout, bus.sum, e[W], e[W-1:0]);
          end
        end
        if (last_out >= 0) begin
          vectors++;
          if (cyc - last_out != D + 2) begin
            miscompares++;
            $display("FAIL b2b_period%0d: got %0d cycles expected %0d", got, cyc - last_out, D + 2);
          end
        end
        last_out = cyc;
        got++;
      end
      if (acc) begin
        expq.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        sent++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (sent < NRND) begin
          bus.a   = W'($urandom);
          bus.b   = W'($urandom);
          bus.cin = 1'($urandom);
          bus.sub = 1'($urandom);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if (got != NRND) begin
      miscompares++;
      $display("FAIL b2b_timeout: got %0d results expected %0d", got, NRND);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a   = '0;
    bus.b   = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_done_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
